// File: rtl/gamepad_cont.sv
// ---------------------------------------------------------------------------
// gamepad_cont
//
// Continuous scanner for SNES-style serial gamepads. A free-running tick
// divider paces a small protocol FSM that selects one pad bank at a time,
// pulses the shared latch line, clocks 16 bits out of every pad in the bank
// and then publishes the 12 meaningful button bits of each pad into a flat,
// registered button map. Scanning runs back to back across all banks while
// ctrl_run is high and stops cleanly at the end of a full sweep.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active-low
//   gp_sel    bank index driven to the pad multiplexer
//   gp_data   serial data, one line per pad in a bank (0 = pressed)
//   gp_latch  latch pulse to the pads (active-high)
//   gp_clk    shift clock to the pads (idles high)
//   gp_value  button map, 12 bits per pad, 1 = pressed;
//             pad p = bank*DATA_WIDTH + line lives at [12p +: 12]
//   ctrl_run  enables continuous scanning
// ---------------------------------------------------------------------------
module gamepad_cont #(
   parameter int DIV        = 15,
   parameter int SEL_WIDTH  = 1,
   parameter int DATA_WIDTH = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   output logic [SEL_WIDTH-1:0]                     gp_sel,
   input  logic [DATA_WIDTH-1:0]                    gp_data,
   output logic                                     gp_latch,
   output logic                                     gp_clk,
   output logic [12*DATA_WIDTH*(2**SEL_WIDTH)-1:0]  gp_value,
   input  logic                                     ctrl_run
);

   localparam int NUM_BANKS   = 2**SEL_WIDTH;
   localparam int VALUE_WIDTH = 12*DATA_WIDTH*NUM_BANKS;
   localparam int CNT_WIDTH   = (DIV < 2) ? 1 : $clog2(DIV+1);

   localparam logic [CNT_WIDTH-1:0] CNT_RELOAD = CNT_WIDTH'(DIV);
   localparam logic [SEL_WIDTH-1:0] LAST_BANK  = SEL_WIDTH'(NUM_BANKS-1);
   localparam logic [3:0]           LAST_BIT   = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      LATCH,
      SHIFT
   } state_t;

   logic [CNT_WIDTH-1:0]               tick_cnt;
   logic                               tick;

   state_t                             state;
   state_t                             state_next;
   logic [SEL_WIDTH-1:0]               sel_next;
   logic                               latch_next;
   logic                               clk_next;
   logic [3:0]                         bit_cnt;
   logic [3:0]                         bit_next;
   logic                               phase;
   logic                               phase_next;
   logic                               latch_hold;
   logic                               hold_next;
   logic [DATA_WIDTH-1:0][15:0]        shreg;
   logic [DATA_WIDTH-1:0][15:0]        shreg_next;
   logic [VALUE_WIDTH-1:0]             value_next;

   // Protocol tick: the counter reloads on the cycle it reaches zero, so a
   // tick occurs every DIV+1 clocks and the first one lands DIV clocks after
   // reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= CNT_RELOAD;
      end else if (tick) begin
         tick_cnt <= CNT_RELOAD;
      end else begin
         tick_cnt <= tick_cnt - CNT_WIDTH'(1);
      end
   end

   assign tick = (tick_cnt == '0);

   // State and output registers. Every pad-facing output comes straight from
   // a flop so the connector lines never glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         gp_sel     <= '0;
         gp_latch   <= 1'b0;
         gp_clk     <= 1'b1;
         bit_cnt    <= '0;
         phase      <= 1'b0;
         latch_hold <= 1'b0;
         shreg      <= '0;
         gp_value   <= '0;
      end else begin
         state      <= state_next;
         gp_sel     <= sel_next;
         gp_latch   <= latch_next;
         gp_clk     <= clk_next;
         bit_cnt    <= bit_next;
         phase      <= phase_next;
         latch_hold <= hold_next;
         shreg      <= shreg_next;
         gp_value   <= value_next;
      end
   end

   // Next-state logic. Nothing moves except on a tick. In SHIFT each bit
   // takes two ticks: the first samples the lines and drops gp_clk, the
   // second raises gp_clk again, which makes the pads present the next bit.
   // The shift registers fill from the top so that after 16 samples the
   // first sampled bit sits at index 0. The button map for the whole bank
   // is written in one go on the final rising edge of gp_clk, so software
   // never sees a half-shifted pad.
   always_comb begin
      state_next = state;
      sel_next   = gp_sel;
      latch_next = gp_latch;
      clk_next   = gp_clk;
      bit_next   = bit_cnt;
      phase_next = phase;
      hold_next  = latch_hold;
      shreg_next = shreg;
      value_next = gp_value;

      if (tick) begin
         case (state)
            IDLE: begin
               latch_next = 1'b0;
               clk_next   = 1'b1;
               if (ctrl_run) begin
                  state_next = SETTLE;
                  sel_next   = '0;
               end
            end

            SETTLE: begin
               state_next = LATCH;
               latch_next = 1'b1;
               hold_next  = 1'b0;
            end

            LATCH: begin
               if (!latch_hold) begin
                  hold_next = 1'b1;
               end else begin
                  state_next = SHIFT;
                  latch_next = 1'b0;
                  bit_next   = '0;
                  phase_next = 1'b0;
               end
            end

            SHIFT: begin
               if (!phase) begin
                  for (int d = 0; d < DATA_WIDTH; d++) begin
                     shreg_next[d] = {gp_data[d], shreg[d][15:1]};
                  end
                  clk_next   = 1'b0;
                  phase_next = 1'b1;
               end else begin
                  clk_next   = 1'b1;
                  phase_next = 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     for (int b = 0; b < NUM_BANKS; b++) begin
                        for (int d = 0; d < DATA_WIDTH; d++) begin
                           if (SEL_WIDTH'(b) == gp_sel) begin
                              value_next[12*(b*DATA_WIDTH+d) +: 12] = ~shreg[d][11:0];
                           end
                        end
                     end
                     bit_next = '0;
                     if (gp_sel != LAST_BANK) begin
                        sel_next   = gp_sel + SEL_WIDTH'(1);
                        state_next = SETTLE;
                     end else begin
                        sel_next   = '0;
                        state_next = ctrl_run ? SETTLE : IDLE;
                     end
                  end else begin
                     bit_next = bit_cnt + 4'd1;
                  end
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gamepad_cont.sv
// ---------------------------------------------------------------------------
// tb_gamepad_cont
//
// Self-checking bench for gamepad_cont. A behavioural pad model sits on the
// connector side: each pad holds a 16-bit word, presents bit 0 while latched
// and advances one bit on every rising edge of gp_clk, like a real shift
// register pad. The expected button map is built from those words whenever
// a pad has been clocked through all 16 bits.
// ---------------------------------------------------------------------------
module tb_gamepad_cont;

   localparam int DIV         = 15;
   localparam int SEL_WIDTH   = 1;
   localparam int DATA_WIDTH  = 2;
   localparam int NUM_BANKS   = 2**SEL_WIDTH;
   localparam int VW          = 12*DATA_WIDTH*NUM_BANKS;
   localparam int TICK        = DIV+1;
   localparam int BANK_CYCLES = 35*TICK;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [SEL_WIDTH-1:0]  gp_sel;
   logic [DATA_WIDTH-1:0] gp_data;
   logic                  gp_latch;
   logic                  gp_clk;
   logic [VW-1:0]         gp_value;
   logic                  ctrl_run = 1'b0;

   int checks   = 0;
   int failures = 0;

   gamepad_cont #(
      .DIV        (DIV),
      .SEL_WIDTH  (SEL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .gp_sel   (gp_sel),
      .gp_data  (gp_data),
      .gp_latch (gp_latch),
      .gp_clk   (gp_clk),
      .gp_value (gp_value),
      .ctrl_run (ctrl_run)
   );

   always #5 clk = ~clk;

   // Pad model state and the expected button map
   logic [15:0]   pad_word [NUM_BANKS][DATA_WIDTH];
   int            pad_idx       = 16;
   int            cur_bank      = 0;
   logic [VW-1:0] exp_value     = '0;
   int            done_count    = 0;
   int            done_bank [$];
   int            stray_changes = 0;
   int            overlap_hits  = 0;
   logic          prev_clk      = 1'b1;
   logic [VW-1:0] prev_value    = '0;
   bit            done_now;

   // Pads drive the bit they currently hold; after 16 bits they read high
   always_comb begin
      gp_data = '1;
      for (int d = 0; d < DATA_WIDTH; d++) begin
         if (pad_idx < 16) begin
            gp_data[d] = pad_word[gp_sel][d][pad_idx[3:0]];
         end
      end
   end

   // Pad-side view of the bus, evaluated mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         pad_idx    = 16;
         exp_value  = '0;
         prev_clk   = 1'b1;
         prev_value = gp_value;
      end else begin
         done_now = 1'b0;
         if (gp_latch) begin
            pad_idx  = 0;
            cur_bank = int'(gp_sel);
         end else if (!prev_clk && gp_clk) begin
            pad_idx++;
            if (pad_idx == 16) begin
               for (int d = 0; d < DATA_WIDTH; d++) begin
                  exp_value[12*(cur_bank*DATA_WIDTH+d) +: 12] = ~pad_word[cur_bank][d][11:0];
               end
               done_count++;
               done_bank.push_back(cur_bank);
               done_now = 1'b1;
            end
         end
         if (gp_value !== prev_value && !done_now) stray_changes++;
         if (gp_latch && !gp_clk) overlap_hits++;
         prev_clk   = gp_clk;
         prev_value = gp_value;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_done(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_count >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (done_count >= target) ok = 1'b1;
   endtask

   task automatic wait_latch(input int sel, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (gp_latch === 1'b1 && int'(gp_sel) == sel) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      ctrl_run = 1'b1;
      pad_word[0][0] = 16'hFFFF;
      pad_word[0][1] = 16'h0000;
      pad_word[1][0] = 16'h0000;
      pad_word[1][1] = 16'hFFFF;
      repeat (3) @(negedge clk);
      checks++; if (gp_sel !== '0) begin failures++; $display("[TB] FAIL reset_sel: got %0h want 0", gp_sel); end
      checks++; if (gp_latch !== 1'b0) begin failures++; $display("[TB] FAIL reset_latch: got %b want 0", gp_latch); end
      checks++; if (gp_clk !== 1'b1) begin failures++; $display("[TB] FAIL reset_clk: got %b want 1", gp_clk); end
      checks++; if (gp_value !== '0) begin failures++; $display("[TB] FAIL reset_value: got %h want 0", gp_value); end
   endtask

   task automatic test_startup_timing();
      int latch_rise = -1;
      int latch_fall = -1;
      int fall_q [$];
      int rise_q [$];
      logic pl = 1'b0;
      logic pc = 1'b1;
      int bad_width = 0;
      int bad_period = 0;
      int n;
      rst = 1'b1;
      for (int k = 1; k <= 580; k++) begin
         @(negedge clk);
         if (gp_latch && !pl && latch_rise < 0) latch_rise = k;
         if (!gp_latch && pl && latch_fall < 0) latch_fall = k;
         if (!gp_clk && pc) fall_q.push_back(k);
         if (gp_clk && !pc) rise_q.push_back(k);
         pl = gp_latch;
         pc = gp_clk;
      end
      checks++; if (latch_rise != 2*TICK) begin failures++; $display("[TB] FAIL latch_rise: got cycle %0d want %0d", latch_rise, 2*TICK); end
      checks++; if (latch_fall - latch_rise != 2*TICK) begin failures++; $display("[TB] FAIL latch_width: got %0d want %0d", latch_fall - latch_rise, 2*TICK); end
      checks++; if (fall_q.size() != 16) begin failures++; $display("[TB] FAIL clk_falls: got %0d want 16", fall_q.size()); end
      checks++; if (rise_q.size() != 16) begin failures++; $display("[TB] FAIL clk_rises: got %0d want 16", rise_q.size()); end
      if (fall_q.size() > 0) begin
         checks++; if (fall_q[0] - latch_fall != TICK) begin failures++; $display("[TB] FAIL latch_to_clk: got %0d want %0d", fall_q[0] - latch_fall, TICK); end
      end
      n = (fall_q.size() < rise_q.size()) ? fall_q.size() : rise_q.size();
      for (int i = 0; i < n; i++) begin
         if (rise_q[i] - fall_q[i] != TICK) bad_width++;
         if (i > 0 && fall_q[i] - fall_q[i-1] != 2*TICK) bad_period++;
      end
      checks++; if (bad_width != 0) begin failures++; $display("[TB] FAIL clk_low_width: got %0d bad pulses want 0", bad_width); end
      checks++; if (bad_period != 0) begin failures++; $display("[TB] FAIL clk_period: got %0d bad periods want 0", bad_period); end
   endtask

   task automatic test_bank_values();
      bit ok;
      wait_done(1, BANK_CYCLES+100, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL bank0_timeout: got %0d banks want 1", done_count); end
      checks++; if (gp_value !== 48'h000000_FFF000) begin failures++; $display("[TB] FAIL bank0_const: got %h want 000000fff000", gp_value); end
      checks++; if (gp_value !== exp_value) begin failures++; $display("[TB] FAIL bank0_model: got %h want %h", gp_value, exp_value); end
      wait_done(2, BANK_CYCLES+100, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL bank1_timeout: got %0d banks want 2", done_count); end
      checks++; if (gp_value !== 48'h000FFF_FFF000) begin failures++; $display("[TB] FAIL bank1_const: got %h want 000ffffff000", gp_value); end
      wait_done(4, 2*BANK_CYCLES+100, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL sweep2_timeout: got %0d banks want 4", done_count); end
      checks++; if (gp_value !== 48'h000FFF_FFF000) begin failures++; $display("[TB] FAIL sweep2_stable: got %h want 000ffffff000", gp_value); end
   endtask

   task automatic test_run_stop();
      bit ok;
      int d0;
      int q0;
      int activity = 0;
      wait_latch(0, 2*BANK_CYCLES+100, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL stop_find_bank0: got no bank0 latch want one"); end
      ctrl_run = 1'b0;
      d0 = done_count;
      q0 = done_bank.size();
      repeat (2*BANK_CYCLES + 200) @(negedge clk);
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (gp_latch || !gp_clk) activity++;
      end
      checks++; if (done_count - d0 != 2) begin failures++; $display("[TB] FAIL stop_bank_count: got %0d want 2", done_count - d0); end
      if (done_bank.size() >= q0 + 2) begin
         checks++; if (done_bank[q0] != 0 || done_bank[q0+1] != 1) begin failures++; $display("[TB] FAIL stop_bank_order: got %0d,%0d want 0,1", done_bank[q0], done_bank[q0+1]); end
      end
      checks++; if (activity != 0) begin failures++; $display("[TB] FAIL stop_idle_activity: got %0d active cycles want 0", activity); end
      checks++; if (gp_sel !== '0 || gp_latch !== 1'b0 || gp_clk !== 1'b1) begin failures++; $display("[TB] FAIL stop_outputs: got sel=%0h latch=%b clk=%b want 0,0,1", gp_sel, gp_latch, gp_clk); end
      checks++; if (gp_value !== exp_value) begin failures++; $display("[TB] FAIL stop_hold: got %h want %h", gp_value, exp_value); end
   endtask

   task automatic test_serial_pattern();
      bit ok;
      int d0;
      pad_word[0][0] = 16'hF7FE;
      pad_word[0][1] = 16'h07FE;
      pad_word[1][0] = 16'h0000;
      pad_word[1][1] = 16'hFFFF;
      d0 = done_count;
      ctrl_run = 1'b1;
      wait_latch(0, 4*TICK, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL restart_bank0: got no bank0 latch want one within %0d cycles", 4*TICK); end
      ctrl_run = 1'b0;
      wait_done(d0+2, 2*BANK_CYCLES+100, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL pattern_timeout: got %0d banks want 2", done_count - d0); end
      checks++; if (gp_value[11:0] !== 12'h801) begin failures++; $display("[TB] FAIL pattern_pad0: got %h want 801", gp_value[11:0]); end
      checks++; if (gp_value[23:12] !== 12'h801) begin failures++; $display("[TB] FAIL pattern_pad1_high_bits: got %h want 801", gp_value[23:12]); end
      checks++; if (gp_value[47:24] !== 24'h000FFF) begin failures++; $display("[TB] FAIL pattern_bank1: got %h want 000fff", gp_value[47:24]); end
      checks++; if (gp_value !== exp_value) begin failures++; $display("[TB] FAIL pattern_model: got %h want %h", gp_value, exp_value); end
      repeat (3*TICK) @(negedge clk);
   endtask

   task automatic test_random_sweeps();
      bit ok;
      int d0;
      for (int r = 0; r < 3; r++) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int d = 0; d < DATA_WIDTH; d++) begin
               pad_word[b][d] = 16'($urandom);
            end
         end
         d0 = done_count;
         ctrl_run = 1'b1;
         for (int n = 1; n <= 4; n++) begin
            wait_done(d0+n, BANK_CYCLES+4*TICK+50, ok);
            checks++; if (!ok) begin failures++; $display("[TB] FAIL rand_timeout: round %0d got %0d banks want %0d", r, done_count - d0, n); end
            checks++; if (gp_value !== exp_value) begin failures++; $display("[TB] FAIL rand_value: round %0d bank %0d got %h want %h", r, n, gp_value, exp_value); end
            checks++; if (done_bank[$] != (n-1) % NUM_BANKS) begin failures++; $display("[TB] FAIL rand_order: got bank %0d want %0d", done_bank[$], (n-1) % NUM_BANKS); end
            if (n == 3) ctrl_run = 1'b0;
         end
         repeat (3*TICK) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_shift();
      bit ok = 1'b0;
      int d0;
      ctrl_run = 1'b1;
      for (int i = 0; i < 3*BANK_CYCLES; i++) begin
         @(negedge clk);
         if (gp_sel === 1'b1 && gp_clk === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (!ok) begin failures++; $display("[TB] FAIL mid_shift_find: got no bank1 shift want one"); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (gp_sel !== '0 || gp_latch !== 1'b0 || gp_clk !== 1'b1) begin failures++; $display("[TB] FAIL async_reset_outputs: got sel=%0h latch=%b clk=%b want 0,0,1", gp_sel, gp_latch, gp_clk); end
      checks++; if (gp_value !== '0) begin failures++; $display("[TB] FAIL async_reset_value: got %h want 0", gp_value); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      d0 = done_count;
      wait_latch(0, 4*TICK, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL post_reset_start: got no bank0 latch want one"); end
      ctrl_run = 1'b0;
      wait_done(d0+2, 2*BANK_CYCLES+100, ok);
      checks++; if (!ok || gp_value !== exp_value) begin failures++; $display("[TB] FAIL post_reset_value: got %h want %h", gp_value, exp_value); end
   endtask

   task automatic test_integrity();
      checks++; if (stray_changes != 0) begin failures++; $display("[TB] FAIL value_atomic: got %0d stray updates want 0", stray_changes); end
      checks++; if (overlap_hits != 0) begin failures++; $display("[TB] FAIL latch_clk_overlap: got %0d cycles want 0", overlap_hits); end
   endtask

   initial begin
      $display("[TB] starting gamepad_cont bench");
      test_reset();
      test_startup_timing();
      test_bank_values();
      test_run_stop();
      test_serial_pattern();
      test_random_sweeps();
      test_reset_mid_shift();
      test_integrity();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
